mem_block_copier: RTL and testbench
===================================

// Module: mem_block_copier
// PURPOSE
//   Initiator for the single-port synchronous-write / asynchronous-read RAM.
//   Copies a block of len words from address src to address dst.
//   For each word it runs one read cycle (oe) and then one write cycle (we)
//   on the RAM pins.
//   Sits between a control FSM / CPU-side register file and the RAM; the
//   RAM's bidirectional data is split here into o_w_wdata and i_w_rdata.
// PARAMETERS
//   p_data_width     8   RAM word width in bits
//   p_address_width  20  RAM address width; address space 2**p_address_width
//   p_len_width      20  width of the block length / word counter
// PORTS
//   i_w_clk      in   1    clock; all state changes on the rising edge
//   i_w_rst_n    in   1    asynchronous active-low reset
//   i_w_start    in   1    start request; sampled only in IDLE
//   i_w_src      in   AW   source base address; latched on an accepted start
//   i_w_dst      in   AW   destination base address; latched on an accepted start
//   i_w_len      in   LW   number of words to copy; latched on an accepted start
//   o_w_busy     out  1    1 while in READ or WRITE
//   o_w_done     out  1    1-cycle pulse when the copy completes
//   o_w_count    out  LW   words written so far in the current copy
//   o_w_address  out  AW   RAM address
//   o_w_wdata    out  DW   RAM write data
//   i_w_rdata    in   DW   RAM read data (valid while o_w_oe=1)
//   o_w_we       out  1    RAM write enable
//   o_w_oe       out  1    RAM output enable
// BEHAVIOUR
//   Reset (async, i_w_rst_n=0): all outputs are registered.
//     - State=IDLE, busy=0, done=0, count=0, address=0, wdata=0.
//     - we=0 and oe=0 take effect immediately, not at the next edge.
//   Internal state: src_q, dst_q, len_q, idx (LW bits), buf_q (DW bits).
//   FSM states and transitions:
//     - IDLE:
//         - start=1 and len!=0: latch src/dst/len, set idx=0 and count=0,
//           go to READ.
//         - start=1 and len==0: go to DONE without touching the RAM.
//         - start=0: stay in IDLE.
//     - READ (one cycle): oe=1, we=0, address=src_q+idx.
//         - At the closing edge, capture buf_q<=i_w_rdata and go to WRITE.
//     - WRITE (one cycle): we=1, oe=0, address=dst_q+idx, wdata=buf_q.
//         - At the closing edge, idx++ and count++.
//         - If idx+1==len_q, go to DONE; otherwise go to READ.
//     - DONE (one cycle): done=1, busy=0, we=oe=0; then go to IDLE.
//         - count holds its final value until the next accepted start.
//   Pin rules:
//     - we and oe are never both 1.
//     - In IDLE and DONE, we=oe=0 and address holds its last value.
//   Latency: start edge -> done pulse = 2*len+1 cycles; len==0 gives 1 cycle.
//   Address arithmetic is modulo 2**p_address_width (wrap-around, no error).
//   Overlapping regions: the copy is always ascending, word by word.
//     - With dst>src and overlap, source words already overwritten are
//       re-copied; this is the defined result.
//   i_w_start outside IDLE (busy or DONE) is ignored and not queued.
//   The src/dst/len inputs may change freely after an accepted start.
//   Reset asserted mid-copy aborts it.
//     - Only words already written (count) have been modified in RAM.
//     - No done pulse is generated.
// TESTING (bench instantiates this block plus the RAM, DW=8, AW=8 for speed)
//   1. Preload RAM[0x10..0x13]=A1,B2,C3,D4; copy src=0x10 dst=0x80 len=4.
//      -> RAM[0x80..0x83]=A1,B2,C3,D4; done pulses 9 cycles after start;
//         count=4.
//   2. len=0 start.
//      -> done pulses next cycle; we/oe never asserted; RAM unchanged.
//   3. src=0xFE dst=0x40 len=4 with RAM[FE,FF,00,01]=11,22,33,44.
//      -> RAM[40..43]=11,22,33,44 (source wraps).
//   4. Start a len=8 copy; pulse start again with other args at cycle 3.
//      -> second start ignored; first copy completes intact.
//   5. Assert reset during the WRITE of word 2 (of len=6).
//      -> we/oe drop at once; only 2 words copied; busy=0; no done pulse.
//   6. Every cycle of all tests: assert !(o_w_we && o_w_oe), and busy==1
//      exactly in READ/WRITE.

Source files
------------

// File: rtl/mem_block_copier.sv
// Block copier driving a single-port RAM: one read cycle and one write cycle per word.
// The copy runs in ascending order; all RAM pins and status outputs are registered.
module mem_block_copier #(
  parameter int p_data_width    = 8,
  parameter int p_address_width = 20,
  parameter int p_len_width     = 20
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_start,
  input  logic [p_address_width-1:0] i_w_src,
  input  logic [p_address_width-1:0] i_w_dst,
  input  logic [p_len_width-1:0]     i_w_len,
  output logic                       o_w_busy,
  output logic                       o_w_done,
  output logic [p_len_width-1:0]     o_w_count,
  output logic [p_address_width-1:0] o_w_address,
  output logic [p_data_width-1:0]    o_w_wdata,
  input  logic [p_data_width-1:0]    i_w_rdata,
  output logic                       o_w_we,
  output logic                       o_w_oe
);

  localparam int AW = p_address_width;
  localparam int LW = p_len_width;
  localparam int DW = p_data_width;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_src;
  logic [AW-1:0]   r_dst;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_idx;
  logic            r_busy;
  logic            r_done;
  logic [LW-1:0]   r_count;
  logic [AW-1:0]   r_address;
  logic [DW-1:0]   r_wdata;
  logic            r_we;
  logic            r_oe;

  logic [AW-1:0]   w_src_nxt;
  logic [AW-1:0]   w_dst_nxt;
  logic [LW-1:0]   w_len_nxt;
  logic [LW-1:0]   w_idx_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [LW-1:0]   w_count_nxt;
  logic [AW-1:0]   w_address_nxt;
  logic [DW-1:0]   w_wdata_nxt;
  logic            w_we_nxt;
  logic            w_oe_nxt;
  logic [LW-1:0]   w_idx_inc;
  logic            w_last;
  logic            w_len_zero;

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_last     = (w_idx_inc == r_len);
  assign w_len_zero = (i_w_len == '0);

  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_address <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_count   <= w_count_nxt;
      r_address <= w_address_nxt;
      r_wdata   <= w_wdata_nxt;
      r_we      <= w_we_nxt;
      r_oe      <= w_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_w_start) begin
          w_state_nxt = w_len_zero ? S_DONE : S_READ;
        end
      end
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pins are registered, so they are derived from the state being entered.
  always_comb begin
    w_busy_nxt    = (w_state_nxt == S_READ) || (w_state_nxt == S_WRITE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_oe_nxt      = (w_state_nxt == S_READ);
    w_we_nxt      = (w_state_nxt == S_WRITE);
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_len_nxt     = r_len;
    w_idx_nxt     = r_idx;
    w_count_nxt   = r_count;
    w_address_nxt = r_address;
    w_wdata_nxt   = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (i_w_start) begin
          w_count_nxt = '0;
          if (!w_len_zero) begin
            w_src_nxt     = i_w_src;
            w_dst_nxt     = i_w_dst;
            w_len_nxt     = i_w_len;
            w_idx_nxt     = '0;
            w_address_nxt = i_w_src;
          end
        end
      end
      S_READ: begin
        w_address_nxt = r_dst + AW'(r_idx);
        w_wdata_nxt   = i_w_rdata;
      end
      S_WRITE: begin
        w_idx_nxt   = w_idx_inc;
        w_count_nxt = r_count + 1'b1;
        if (!w_last) begin
          w_address_nxt = r_src + AW'(w_idx_inc);
        end
      end
      S_DONE: begin
      end
      default: begin
      end
    endcase
  end

  assign o_w_busy    = r_busy;
  assign o_w_done    = r_done;
  assign o_w_count   = r_count;
  assign o_w_address = r_address;
  assign o_w_wdata   = r_wdata;
  assign o_w_we      = r_we;
  assign o_w_oe      = r_oe;

endmodule

// File: tb/tb_mem_block_copier.sv
// Bench for mem_block_copier: RAM model, expected pin-access queue and
// a shadow memory image updated word by word in copy order.
module tb_mem_block_copier;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 8;

  typedef struct packed {
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] c;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] count;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          we;
  logic          oe;

  logic [7:0] mem  [256];
  logic [7:0] img  [256];
  logic [7:0] refm [256];
  logic       pl = 1'b0;
  acc_t       q[$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  mem_block_copier #(
    .p_data_width(DW),
    .p_address_width(AW),
    .p_len_width(LW)
  ) dut (
    .i_w_clk(clk),
    .i_w_rst_n(rst_n),
    .i_w_start(start),
    .i_w_src(src),
    .i_w_dst(dst),
    .i_w_len(len),
    .o_w_busy(busy),
    .o_w_done(done),
    .o_w_count(count),
    .o_w_address(addr),
    .o_w_wdata(wdata),
    .i_w_rdata(rdata),
    .o_w_we(we),
    .o_w_oe(oe)
  );

  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else if (pl) for (int i = 0; i < 256; i++) mem[i] <= img[i];
  end

  assign rdata = oe ? mem[addr] : 8'h00;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      acc_t e;
      chk("excl", 32'(we & oe), 32'd0);
      chk("busy", 32'(busy), 32'(we | oe));
      if (we | oe) begin
        chk("acc_queued", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("acc_kind", 32'(we), 32'(e.wr));
          chk("acc_addr", 32'(addr), 32'(e.a));
          chk("acc_cnt", 32'(count), 32'(e.c));
          if (e.wr) chk("acc_wdata", 32'(wdata), 32'(e.d));
        end
      end
    end
  end

  task automatic load();
    @(negedge clk);
    pl = 1'b1;
    @(negedge clk);
    pl = 1'b0;
    refm = img;
  endtask

  task automatic chk_ram();
    int diff;
    diff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) diff++;
    chk("ram_image", diff, 0);
  endtask

  // abort_at: cycle number (edges since start) at which reset is pulsed.
  task automatic copy(input logic [7:0] s, input logic [7:0] d,
                      input int n, input int restart_at,
                      input int abort_at, output int lat);
    int   cyc;
    int   nacc;
    int   nwr;
    logic saw;
    acc_t e;
    logic [7:0] v;
    nacc = (abort_at > 0) ? (abort_at - 2) / 2 + 1 : n;
    nwr  = (abort_at > 0) ? nacc - 1 : n;
    for (int i = 0; i < nacc; i++) begin
      v = refm[8'(s + 8'(i))];
      e = '{wr: 1'b0, a: 8'(s + 8'(i)), d: 8'h00, c: 8'(i)};
      q.push_back(e);
      e = '{wr: 1'b1, a: 8'(d + 8'(i)), d: v, c: 8'(i)};
      q.push_back(e);
      if (i < nwr) refm[8'(d + 8'(i))] = v;
    end
    @(negedge clk);
    start = 1'b1;
    src = s;
    dst = d;
    len = 8'(n);
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0;
    src = 8'($urandom);
    dst = 8'($urandom);
    len = 8'($urandom);
    while (!done && cyc < 2 * n + 30) begin
      if (cyc == restart_at) begin
        start = 1'b1;
        src = 8'($urandom);
        dst = 8'($urandom);
        len = 8'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_oe", 32'(oe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        q.delete();
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
          @(negedge clk);
          saw = saw | done;
        end
        chk("abort_nodone", 32'(saw), 32'd0);
        chk_ram();
        lat = -1;
        return;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    lat = cyc;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", cyc, 2 * n + 1);
    chk("queue_drained", q.size(), 0);
    if (n != 0) chk("final_count", 32'(count), 32'(n));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    if (n != 0) chk("count_hold", 32'(count), 32'(n));
    chk_ram();
  endtask

  initial begin
    int          lat;
    logic [7:0]  s;
    logic [7:0]  d;
    int          n;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    rst_n = 1'b1;

    img[8'h10] = 8'hA1;
    img[8'h11] = 8'hB2;
    img[8'h12] = 8'hC3;
    img[8'h13] = 8'hD4;
    load();
    copy(8'h10, 8'h80, 4, 0, 0, lat);
    chk("t1_lat", lat, 9);
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_ram", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]},
        32'hA1B2C3D4);

    copy(8'h55, 8'h66, 0, 0, 0, lat);
    chk("t2_lat", lat, 1);

    img = refm;
    img[8'hFE] = 8'h11;
    img[8'hFF] = 8'h22;
    img[8'h00] = 8'h33;
    img[8'h01] = 8'h44;
    load();
    copy(8'hFE, 8'h40, 4, 0, 0, lat);
    chk("t3_ram", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]},
        32'h11223344);

    copy(8'h20, 8'hA0, 8, 3, 0, lat);
    chk("t4_lat", lat, 17);

    img = refm;
    for (int i = 0; i < 6; i++) begin
      img[8'h30 + i] = 8'(i + 1);
      img[8'hC0 + i] = 8'h00;
    end
    load();
    copy(8'h30, 8'hC0, 6, 0, 6, lat);
    chk("t5_ram", {8'h00, mem[8'hC0], mem[8'hC1], mem[8'hC2]},
        32'h00010200);

    for (int k = 0; k < 14; k++) begin
      s = 8'($urandom);
      n = $urandom_range(0, 12);
      if (k % 3 == 0) d = 8'(s + 8'($urandom_range(1, 3)));
      else if (k % 3 == 1) d = 8'(s - 8'($urandom_range(1, 3)));
      else d = 8'($urandom);
      copy(s, d, n, (k % 4 == 0) ? 4 : 0, 0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
